ad9833_cfg_sequencer: RTL and testbench

//  Upstream word sequencer for the AD9833 SPI engine. On a single update request it

---
 rtl/ad9833_cfg_sequencer_if.sv | 25 ++
 rtl/ad9833_cfg_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ad9833_cfg_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9833_cfg_sequencer_if.sv
// Request/engine bundle between a controller, the AD9833 word sequencer and the SPI engine.
// Handshake: update_req_i is a one-cycle request that is always taken; start_pluse_o is a
// one-cycle strobe and the engine owns the word until busy_i has risen and fallen again.
interface ad9833_cfg_sequencer_if;
   logic        update_req_i;
   logic [27:0] freq_word_i;
   logic [11:0] phase_word_i;
   logic [1:0]  wave_sel_i;
   logic [15:0] cfg_data_o;
   logic        start_pluse_o;
   logic        busy_i;
   logic        seq_busy_o;
   logic        done_o;
   logic        err_timeout_o;

   modport master (
      output update_req_i, freq_word_i, phase_word_i, wave_sel_i, busy_i,
      input  cfg_data_o, start_pluse_o, seq_busy_o, done_o, err_timeout_o
   );

   modport slave (
      input  update_req_i, freq_word_i, phase_word_i, wave_sel_i, busy_i,
      output cfg_data_o, start_pluse_o, seq_busy_o, done_o, err_timeout_o
   );
endinterface

// File: rtl/ad9833_cfg_sequencer.sv
// Turns one update request into the five-word AD9833 FREQ0/PHASE0 programming sequence
// and feeds it word by word to the SPI engine over its start-pulse/busy handshake.
module ad9833_cfg_sequencer #(
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      sys_clk_i,
   input  logic                      rst_i,
   ad9833_cfg_sequencer_if.slave     bus,
   output logic [2:0]                dbg_state_o
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      GAP     = 3'd4,
      FINISH  = 3'd5
   } state_t;

   state_t       state;
   logic [2:0]   idx;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;

   logic [27:0]  sh_freq;
   logic [11:0]  sh_phase;
   logic [1:0]   sh_wave;

   logic         pend;
   logic [27:0]  pend_freq;
   logic [11:0]  pend_phase;
   logic [1:0]   pend_wave;

   logic [15:0]  cfg_data_r;
   logic         start_r;
   logic         seq_busy_r;
   logic         done_r;
   logic         err_r;

   // Word 0 is a constant, so a fresh sequence can launch before the shadow regs update.
   function automatic logic [15:0] word_of(input logic [2:0]  i,
                                           input logic [27:0] f,
                                           input logic [11:0] p,
                                           input logic [1:0]  w);
      logic [15:0] ctrl;
      case (w)
         2'd0:    ctrl = 16'h2000;
         2'd1:    ctrl = 16'h2002;
         2'd2:    ctrl = 16'h2020;
         default: ctrl = 16'h2028;
      endcase
      case (i)
         3'd0:    word_of = 16'h2100;
         3'd1:    word_of = {2'b01, f[13:0]};
         3'd2:    word_of = {2'b01, f[27:14]};
         3'd3:    word_of = {4'hC, p};
         default: word_of = ctrl;
      endcase
   endfunction

   always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         idx        <= 3'd0;
         gap_cnt    <= '0;
         to_cnt     <= '0;
         sh_freq    <= '0;
         sh_phase   <= '0;
         sh_wave    <= '0;
         pend       <= 1'b0;
         pend_freq  <= '0;
         pend_phase <= '0;
         pend_wave  <= '0;
         cfg_data_r <= '0;
         start_r    <= 1'b0;
         seq_busy_r <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         start_r <= 1'b0;
         done_r  <= 1'b0;

         // Requests arriving mid-sequence park here; later branches may override.
         if (bus.update_req_i && state != IDLE) begin
            pend       <= 1'b1;
            pend_freq  <= bus.freq_word_i;
            pend_phase <= bus.phase_word_i;
            pend_wave  <= bus.wave_sel_i;
         end

         case (state)
            IDLE: begin
               if (bus.update_req_i) begin
                  sh_freq    <= bus.freq_word_i;
                  sh_phase   <= bus.phase_word_i;
                  sh_wave    <= bus.wave_sel_i;
                  err_r      <= 1'b0;
                  idx        <= 3'd0;
                  seq_busy_r <= 1'b1;
                  cfg_data_r <= 16'h2100;
                  start_r    <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               to_cnt <= TW'(1);
               state  <= WAIT_HI;
            end
            WAIT_HI: begin
               if (bus.busy_i) begin
                  state <= WAIT_LO;
               end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  err_r      <= 1'b1;
                  pend       <= 1'b0;
                  seq_busy_r <= 1'b0;
                  state      <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            WAIT_LO: begin
               if (!bus.busy_i) begin
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  if (idx == 3'd4) begin
                     done_r <= 1'b1;
                     state  <= FINISH;
                  end else begin
                     idx        <= idx + 3'd1;
                     cfg_data_r <= word_of(idx + 3'd1, sh_freq, sh_phase, sh_wave);
                     start_r    <= 1'b1;
                     state      <= START;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            FINISH: begin
               // A request landing in this very cycle is newer than anything pending.
               if (bus.update_req_i || pend) begin
                  sh_freq    <= bus.update_req_i ? bus.freq_word_i  : pend_freq;
                  sh_phase   <= bus.update_req_i ? bus.phase_word_i : pend_phase;
                  sh_wave    <= bus.update_req_i ? bus.wave_sel_i   : pend_wave;
                  pend       <= 1'b0;
                  idx        <= 3'd0;
                  cfg_data_r <= 16'h2100;
                  start_r    <= 1'b1;
                  state      <= START;
               end else begin
                  seq_busy_r <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               seq_busy_r <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.cfg_data_o    = cfg_data_r;
   assign bus.start_pluse_o = start_r;
   assign bus.seq_busy_o    = seq_busy_r;
   assign bus.done_o        = done_r;
   assign bus.err_timeout_o = err_r;
   assign dbg_state_o       = state;

endmodule

// File: tb/tb_ad9833_cfg_sequencer.sv
// Directed bench for the AD9833 word sequencer: a small SPI engine model, a word monitor
// and an expected-word scoreboard with hand-computed programming sequences.
module tb_ad9833_cfg_sequencer;
   localparam int GAP = 4;
   localparam int TO  = 16;

   // Clock / reset
   logic       sys_clk = 1'b0;
   logic       rst     = 1'b0;
   logic [2:0] dbg_state;
   always #5 sys_clk = ~sys_clk;

   ad9833_cfg_sequencer_if bus();

   ad9833_cfg_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .sys_clk_i  (sys_clk),
      .rst_i      (rst),
      .bus        (bus),
      .dbg_state_o(dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Engine model: takes the word on a start pulse, raises busy one cycle later,
   // shifts 16 bits MSB-first and holds busy for eng_len cycles.
   bit          eng_en  = 1'b1;
   int          eng_len = 20;
   logic [15:0] sd_q[$];

   initial begin
      bus.busy_i = 1'b0;
      forever begin
         @(posedge sys_clk); #1;
         if (eng_en && !rst && bus.start_pluse_o) begin : eng_word
            logic [15:0] sh;
            logic [15:0] cap;
            bit          ab;
            sh  = bus.cfg_data_o;
            cap = '0;
            ab  = 1'b0;
            @(posedge sys_clk); #1;
            bus.busy_i = 1'b1;
            for (int i = 0; i < eng_len; i++) begin
               @(posedge sys_clk); #1;
               if (rst) begin
                  ab = 1'b1;
                  break;
               end
               if (i < 16) begin
                  cap = {cap[14:0], sh[15]};
                  sh  = {sh[14:0], 1'b0};
               end
            end
            bus.busy_i = 1'b0;
            if (!ab) sd_q.push_back(cap);
         end
      end
   end

   // Monitor: words at start pulses, done pulses, word stability, busy-fall to start gap.
   int          cyc = 0, n_start = 0, n_done = 0, stable_viol = 0, fall_cyc = -1;
   bit          tracking = 1'b0, seen_hi = 1'b0;
   logic [15:0] held = '0;
   logic [15:0] words_q[$];
   int          gaps_q[$];

   always @(negedge sys_clk) begin
      cyc++;
      if (rst) begin
         tracking = 1'b0;
         fall_cyc = -1;
      end else begin
         if (bus.start_pluse_o) begin
            n_start++;
            words_q.push_back(bus.cfg_data_o);
            held     = bus.cfg_data_o;
            tracking = 1'b1;
            seen_hi  = 1'b0;
            if (fall_cyc >= 0) gaps_q.push_back(cyc - fall_cyc);
            fall_cyc = -1;
         end else if (tracking) begin
            if (bus.cfg_data_o !== held) stable_viol++;
            if (bus.busy_i) seen_hi = 1'b1;
            else if (seen_hi) begin
               tracking = 1'b0;
               fall_cyc = cyc;
            end
         end
         if (bus.done_o) begin
            n_done++;
            fall_cyc = -1;
         end
      end
   end

   // Scoreboard
   logic [15:0] exp_q[$];
   logic [15:0] sd_exp_q[$];

   task automatic clear_sb();
      exp_q.delete(); sd_exp_q.delete(); words_q.delete(); sd_q.delete(); gaps_q.delete();
   endtask

   task automatic push_exp(input logic [15:0] a, b, c, d, e);
      logic [15:0] w[5];
      w = '{a, b, c, d, e};
      foreach (w[i]) begin
         exp_q.push_back(w[i]);
         sd_exp_q.push_back(w[i]);
      end
   endtask

   task automatic check_words(input string tag);
      int n;
      n = exp_q.size();
      check({tag, "_nwords"}, 32'(words_q.size()), 32'(n));
      check({tag, "_nsdata"}, 32'(sd_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         logic [15:0] e, g, s;
         e = exp_q.pop_front();
         g = (words_q.size() > 0) ? words_q.pop_front() : 16'hxxxx;
         check($sformatf("%s_word%0d", tag, i), {16'h0, g}, {16'h0, e});
         e = sd_exp_q.pop_front();
         s = (sd_q.size() > 0) ? sd_q.pop_front() : 16'hxxxx;
         check($sformatf("%s_sdata%0d", tag, i), {16'h0, s}, {16'h0, e});
      end
   endtask

   // Driver tasks
   task automatic send_req(input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
      @(negedge sys_clk);
      bus.freq_word_i  = f;
      bus.phase_word_i = p;
      bus.wave_sel_i   = w;
      bus.update_req_i = 1'b1;
      @(negedge sys_clk);
      bus.update_req_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while ((bus.seq_busy_o || dbg_state != 3'd0) && k < budget) begin
         @(negedge sys_clk);
         k++;
      end
      check({tag, "_idle_in_budget"}, 32'(k < budget), 32'd1);
   endtask

   task automatic wait_starts(input string tag, input int target, input int budget);
      int k;
      k = 0;
      while (n_start < target && k < budget) begin
         @(negedge sys_clk);
         k++;
      end
      check({tag, "_start_in_budget"}, 32'(k < budget), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_done, base_start;
      logic [15:0] ctrl_tab[4];
      ctrl_tab = '{16'h2000, 16'h2002, 16'h2020, 16'h2028};

      bus.update_req_i = 1'b0;
      bus.freq_word_i  = '0;
      bus.phase_word_i = '0;
      bus.wave_sel_i   = '0;

      // Reset state
      #2 rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst_cfg_data", {16'h0, bus.cfg_data_o}, 32'h0);
      check("rst_start",    {31'h0, bus.start_pluse_o}, 32'h0);
      check("rst_seq_busy", {31'h0, bus.seq_busy_o}, 32'h0);
      check("rst_done",     {31'h0, bus.done_o}, 32'h0);
      check("rst_err",      {31'h0, bus.err_timeout_o}, 32'h0);
      check("rst_state",    {29'h0, dbg_state}, 32'h0);
      @(posedge sys_clk); #3 rst = 1'b0;

      // Basic sine sequence
      clear_sb();
      base_done = n_done;
      base_start = n_start;
      push_exp(16'h2100, 16'h7DD4, 16'h4001, 16'hC400, 16'h2000);
      send_req(28'h0007DD4, 12'h400, 2'd0);
      check("sine_seq_busy", {31'h0, bus.seq_busy_o}, 32'h1);
      wait_idle("sine", 600);
      repeat (2) @(negedge sys_clk);
      check_words("sine");
      check("sine_starts", 32'(n_start - base_start), 32'd5);
      check("sine_dones",  32'(n_done - base_done), 32'd1);

      // Other waveforms: only the control word changes
      for (int w = 1; w < 4; w++) begin
         clear_sb();
         base_done = n_done;
         push_exp(16'h2100, 16'h7DD4, 16'h4001, 16'hC400, ctrl_tab[w]);
         send_req(28'h0007DD4, 12'h400, 2'(w));
         wait_idle($sformatf("wave%0d", w), 600);
         repeat (2) @(negedge sys_clk);
         check_words($sformatf("wave%0d", w));
         check($sformatf("wave%0d_dones", w), 32'(n_done - base_done), 32'd1);
      end

      // Two requests during a sequence: only the later one (B) runs afterwards
      clear_sb();
      base_done  = n_done;
      base_start = n_start;
      push_exp(16'h2100, 16'h7DD4, 16'h4001, 16'hC400, 16'h2000);
      push_exp(16'h2100, 16'h5EF0, 16'h6AF3, 16'hCABC, 16'h2028);
      send_req(28'h0007DD4, 12'h400, 2'd0);
      wait_starts("pend_a", base_start + 2, 300);
      send_req(28'h1234567, 12'h123, 2'd1);
      wait_starts("pend_b", base_start + 3, 300);
      send_req(28'hABCDEF0, 12'hABC, 2'd3);
      wait_idle("pend", 1200);
      repeat (2) @(negedge sys_clk);
      check_words("pend");
      check("pend_dones", 32'(n_done - base_done), 32'd2);

      // Engine never answers: timeout abort, sticky error, cleared by next accept
      clear_sb();
      eng_en     = 1'b0;
      base_done  = n_done;
      base_start = n_start;
      @(negedge sys_clk);
      bus.freq_word_i  = 28'h0000123;
      bus.phase_word_i = 12'h001;
      bus.wave_sel_i   = 2'd0;
      bus.update_req_i = 1'b1;
      @(negedge sys_clk);
      bus.update_req_i = 1'b0;
      repeat (TO - 1) @(negedge sys_clk);
      check("to_err_before",  {31'h0, bus.err_timeout_o}, 32'h0);
      check("to_busy_before", {31'h0, bus.seq_busy_o}, 32'h1);
      @(negedge sys_clk);
      check("to_err_set",     {31'h0, bus.err_timeout_o}, 32'h1);
      check("to_busy_clr",    {31'h0, bus.seq_busy_o}, 32'h0);
      check("to_state_idle",  {29'h0, dbg_state}, 32'h0);
      repeat (10) @(negedge sys_clk);
      check("to_err_sticky",  {31'h0, bus.err_timeout_o}, 32'h1);
      check("to_no_done",     32'(n_done - base_done), 32'd0);
      check("to_one_start",   32'(n_start - base_start), 32'd1);
      eng_en = 1'b1;
      clear_sb();
      push_exp(16'h2100, 16'h4123, 16'h4000, 16'hC001, 16'h2000);
      send_req(28'h0000123, 12'h001, 2'd0);
      check("to_err_cleared", {31'h0, bus.err_timeout_o}, 32'h0);
      wait_idle("to_retry", 600);
      repeat (2) @(negedge sys_clk);
      check_words("to_retry");

      // Long engine busy: word stable while engine busy, gap of GAP+1 cycles
      clear_sb();
      eng_len     = 70;
      stable_viol = 0;
      push_exp(16'h2100, 16'h4001, 16'h6000, 16'hCFFF, 16'h2020);
      send_req(28'h8000001, 12'hFFF, 2'd2);
      wait_idle("long", 1500);
      repeat (2) @(negedge sys_clk);
      check("long_stable_viol", 32'(stable_viol), 32'd0);
      check("long_ngaps", 32'(gaps_q.size()), 32'd4);
      foreach (gaps_q[i]) check($sformatf("long_gap%0d", i), 32'(gaps_q[i]), 32'(GAP + 1));
      check_words("long");
      eng_len = 20;

      // Reset in the middle of word 2
      clear_sb();
      base_start = n_start;
      send_req(28'h0007DD4, 12'h400, 2'd0);
      wait_starts("mid_rst", base_start + 3, 300);
      repeat (5) @(negedge sys_clk);
      check("mid_rst_busy_pre", {31'h0, bus.busy_i}, 32'h1);
      @(posedge sys_clk); #3 rst = 1'b1;
      #1;
      check("mid_rst_cfg_data", {16'h0, bus.cfg_data_o}, 32'h0);
      check("mid_rst_start",    {31'h0, bus.start_pluse_o}, 32'h0);
      check("mid_rst_seq_busy", {31'h0, bus.seq_busy_o}, 32'h0);
      check("mid_rst_done",     {31'h0, bus.done_o}, 32'h0);
      check("mid_rst_err",      {31'h0, bus.err_timeout_o}, 32'h0);
      check("mid_rst_state",    {29'h0, dbg_state}, 32'h0);
      repeat (2) @(posedge sys_clk);
      #3 rst = 1'b0;
      base_start = n_start;
      repeat (100) @(negedge sys_clk);
      check("mid_rst_no_starts", 32'(n_start - base_start), 32'd0);
      check("mid_rst_idle",      {31'h0, bus.seq_busy_o}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
